// File: rtl/aes_block_packer.sv
// rtl/aes_block_packer.sv - byte-to-block packer feeding the AES datapath
// Packs bytes MSB-first into a NUM_BYTES block and hands it off over valid/ready.
module aes_block_packer #(
  parameter int NUM_BYTES = 16,
  parameter int CNT_BITS  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic [8*NUM_BYTES-1:0] block_out,
  output logic                   block_valid,
  input  logic                   block_ready,
  output logic [CNT_BITS-1:0]    byte_count
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CNT_BITS-1:0] LAST_SLOT = CNT_BITS'(NUM_BYTES - 1);
  localparam logic [CNT_BITS-1:0] FULL_CNT  = CNT_BITS'(NUM_BYTES);

  state_t              state;
  logic [CNT_BITS-1:0] slot;

  // Slot counts bytes from the LSB end, so the first byte lands in the top byte.
  assign slot       = LAST_SLOT - byte_count;
  assign byte_ready = (state == FILL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      block_valid <= 1'b0;
      byte_count  <= '0;
      block_out   <= '0;
    end else if (clear) begin
      state       <= FILL;
      block_valid <= 1'b0;
      byte_count  <= '0;
      block_out   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (byte_valid) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
              if (slot == CNT_BITS'(i)) begin
                block_out[8*i +: 8] <= byte_in;
              end
            end
            byte_count <= byte_count + CNT_BITS'(1);
            if (byte_count == LAST_SLOT) begin
              state       <= FULL;
              block_valid <= 1'b1;
            end
          end
        end
        FULL: begin
          // Old block contents stay; the next fill overwrites them byte by byte.
          if (block_ready) begin
            state       <= FILL;
            block_valid <= 1'b0;
            byte_count  <= '0;
          end
        end
        default: begin
          state       <= FILL;
          block_valid <= 1'b0;
          byte_count  <= '0;
        end
      endcase
    end
  end

  initial assert (2 ** CNT_BITS > NUM_BYTES);

endmodule
